// File: rtl/viterbi_decoder_pkg.sv
// conv_code_pkg: rate-1/2 K=3 code constants, trellis types and encoder parity model
package conv_code_pkg;
  localparam int K = 3;
  localparam logic [K-1:0] G0 = 3'b101;
  localparam logic [K-1:0] G1 = 3'b111;
  localparam int NUM_STATES = 1 << (K - 1);
  typedef logic [K-2:0] state_t;
  typedef enum logic {RUN, DRAIN} fsm_t;
  function automatic logic [1:0] exp_par(input state_t s, input logic u);
    return {^({u, s} & G0), ^({u, s} & G1)};
  endfunction
  function automatic logic [1:0] hamming2(input logic [1:0] x);
    return {1'b0, x[1]} + {1'b0, x[0]};
  endfunction
endpackage

// File: rtl/viterbi_decoder_if.sv
// viterbi_decoder_if: received-symbol handshake in, decoded-bit stream out
interface viterbi_decoder_if;
  logic [1:0] sym;
  logic sym_valid;
  logic sym_last;
  logic sym_ready;
  logic bit_out;
  logic bit_valid;
  logic bit_last;
  modport master (output sym, sym_valid, sym_last, input sym_ready, bit_out, bit_valid, bit_last);
  modport slave (input sym, sym_valid, sym_last, output sym_ready, bit_out, bit_valid, bit_last);
endinterface

// File: rtl/viterbi_decoder_acs.sv
// viterbi_acs: compare-select of two candidate path metrics for one trellis state
module viterbi_acs #(
  parameter int PM_W = 6
) (
  input  logic [PM_W-1:0] cand0_i,
  input  logic [PM_W-1:0] cand1_i,
  output logic [PM_W-1:0] pm_o,
  output logic            dec_o
);
  assign dec_o = cand1_i < cand0_i;
  assign pm_o = dec_o ? cand1_i : cand0_i;
endmodule

// File: rtl/viterbi_decoder.sv
// viterbi_decoder: hard-decision K=3 Viterbi decoder with register-exchange survivors
module viterbi_decoder
  import conv_code_pkg::*;
#(
  parameter int TB_DEPTH = 16,
  parameter int PM_W = 6
) (
  input logic clk,
  input logic rst,
  viterbi_decoder_if.slave bus
);
  localparam int CW = $clog2(TB_DEPTH);
  typedef logic [PM_W-1:0] pm_t;
  typedef logic [TB_DEPTH-1:0] sv_t;
  localparam pm_t PM_INIT = pm_t'(1) << (PM_W - 2);
  localparam pm_t PM_MSB = pm_t'(1) << (PM_W - 1);
  localparam pm_t PM_RST [NUM_STATES] = '{'0, PM_INIT, PM_INIT, PM_INIT};
  fsm_t state_q, state_d;
  pm_t pm_q [NUM_STATES];
  pm_t pm_d [NUM_STATES];
  pm_t pm_acs [NUM_STATES];
  pm_t pm_norm [NUM_STATES];
  sv_t surv_q [NUM_STATES];
  sv_t surv_d [NUM_STATES];
  sv_t surv_acs [NUM_STATES];
  logic [NUM_STATES-1:0] dec;
  logic [CW-1:0] cnt_q, cnt_d;
  logic bit_out_q, bit_out_d;
  logic bit_valid_q, bit_valid_d;
  logic bit_last_q, bit_last_d;
  logic norm;
  state_t best_new, best_cur;
  function automatic state_t best_of(input pm_t m [NUM_STATES]);
    state_t b = '0;
    for (int i = 1; i < NUM_STATES; i++) if (m[i] < m[b]) b = state_t'(i);
    return b;
  endfunction
  // next state n={b,a} is reached from {a,0} or {a,1} with input bit b
  for (genvar n = 0; n < NUM_STATES; n++) begin : g_acs
    localparam logic A = 1'(n % 2);
    localparam logic B = 1'(n / 2);
    pm_t c0, c1;
    sv_t sp;
    assign c0 = pm_q[{A, 1'b0}] + pm_t'(hamming2(bus.sym ^ exp_par({A, 1'b0}, B)));
    assign c1 = pm_q[{A, 1'b1}] + pm_t'(hamming2(bus.sym ^ exp_par({A, 1'b1}, B)));
    viterbi_acs #(.PM_W(PM_W)) u_acs (.cand0_i(c0), .cand1_i(c1), .pm_o(pm_acs[n]), .dec_o(dec[n]));
    assign sp = dec[n] ? surv_q[{A, 1'b1}] : surv_q[{A, 1'b0}];
    assign surv_acs[n] = {sp[TB_DEPTH-2:0], B};
  end
  always_comb begin
    norm = 1'b1;
    for (int i = 0; i < NUM_STATES; i++) norm &= pm_acs[i][PM_W-1];
    for (int i = 0; i < NUM_STATES; i++) pm_norm[i] = norm ? pm_acs[i] & ~PM_MSB : pm_acs[i];
  end
  assign best_new = best_of(pm_norm);
  assign best_cur = best_of(pm_q);
  // cnt_q is the fill count in RUN and the count of bits left to drain in DRAIN
  always_comb begin
    state_d = state_q;
    pm_d = pm_q;
    surv_d = surv_q;
    cnt_d = cnt_q;
    bit_out_d = 1'b0;
    bit_valid_d = 1'b0;
    bit_last_d = 1'b0;
    if (state_q == DRAIN) begin
      bit_valid_d = 1'b1;
      bit_out_d = surv_q[best_cur][cnt_q - CW'(1)];
      bit_last_d = cnt_q == CW'(1);
      cnt_d = cnt_q - CW'(1);
      if (bit_last_d) begin
        state_d = RUN;
        pm_d = PM_RST;
        surv_d = '{default: '0};
      end
    end else if (bus.sym_valid) begin
      pm_d = pm_norm;
      surv_d = surv_acs;
      bit_valid_d = cnt_q == CW'(TB_DEPTH - 1);
      bit_out_d = bit_valid_d & surv_acs[best_new][TB_DEPTH-1];
      cnt_d = bit_valid_d ? cnt_q : cnt_q + CW'(1);
      state_d = bus.sym_last ? DRAIN : RUN;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pm_q <= PM_RST;
      surv_q <= '{default: '0};
      cnt_q <= '0;
      bit_out_q <= 1'b0;
      bit_valid_q <= 1'b0;
      bit_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pm_q <= pm_d;
      surv_q <= surv_d;
      cnt_q <= cnt_d;
      bit_out_q <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      bit_last_q <= bit_last_d;
    end
  end
  assign bus.sym_ready = state_q == RUN;
  assign bus.bit_out = bit_out_q;
  assign bus.bit_valid = bit_valid_q;
  assign bus.bit_last = bit_last_q;
endmodule

// File: tb/tb_viterbi_decoder.sv
// tb_viterbi_decoder: directed frames with a queued scoreboard checked by an output monitor
module tb_viterbi_decoder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  viterbi_decoder_if bus ();
  viterbi_decoder #(.TB_DEPTH(16), .PM_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  int nbit = 0;
  bit mute = 1'b0;
  bit pm_watch = 1'b0;
  int pm_max = 0;
  logic [1:0] exp_q [$];
  logic info [$];
  logic [1:0] syms [$];
  task automatic chk(input string name, input int got, input int req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got=%0d required=%0d", name, got, req);
    end
  endtask
  // monitor: every presented bit must match the head of the expectation queue
  always @(negedge clk) begin
    if (!rst && !mute && bus.bit_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_bit #%0d: got bit=%0b last=%0b, required no output", nbit, bus.bit_out, bus.bit_last);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        if ({bus.bit_out, bus.bit_last} !== e)
          begin
            errors++;
            $display("FAIL bit #%0d: got bit=%0b last=%0b, required bit=%0b last=%0b", nbit, bus.bit_out, bus.bit_last, e[1], e[0]);
          end
      end
      nbit++;
    end
  end
  always @(negedge clk) if (pm_watch && int'(dut.pm_q[0]) > pm_max) pm_max = int'(dut.pm_q[0]);
  task automatic set_info(input logic [31:0] v, input int n);
    info.delete();
    for (int i = n - 1; i >= 0; i--) info.push_back(v[i]);
  endtask
  task automatic set_syms(input logic [63:0] v, input int n);
    syms.delete();
    for (int i = n - 1; i >= 0; i--) syms.push_back(v[2*i +: 2]);
  endtask
  task automatic encode();
    logic [1:0] st;
    st = 2'b00;
    syms.delete();
    foreach (info[i]) begin
      syms.push_back({info[i] ^ st[0], info[i] ^ st[1] ^ st[0]});
      st = {info[i], st[1]};
    end
  endtask
  task automatic send(input logic [1:0] s, input logic l);
    int t;
    t = 0;
    while (bus.sym_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (bus.sym_ready !== 1'b1) chk("sym_ready_timeout", 0, 1);
    bus.sym = s;
    bus.sym_valid = 1'b1;
    bus.sym_last = l;
    @(negedge clk);
    bus.sym_valid = 1'b0;
    bus.sym_last = 1'b0;
  endtask
  task automatic send_frame(input bit gaps, input bit push);
    if (push) foreach (info[i]) exp_q.push_back({info[i], 1'(i == info.size() - 1)});
    foreach (syms[i]) begin
      if (gaps) for (int g = 0; g < 8 && $urandom_range(0, 1) == 1; g++) @(negedge clk);
      send(syms[i], 1'(i == syms.size() - 1));
    end
  endtask
  task automatic wait_empty(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || bus.sym_ready !== 1'b1) && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask
  initial begin
    int n;
    bus.sym = 2'b00;
    bus.sym_valid = 1'b0;
    bus.sym_last = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_sym_ready", int'(bus.sym_ready), 1);
    chk("rst_bit_valid", int'(bus.bit_valid), 0);
    chk("rst_bit_out", int'(bus.bit_out), 0);
    chk("rst_bit_last", int'(bus.bit_last), 0);
    rst = 1'b0;
    @(negedge clk);
    // info 1,0,1,1 + 12 zeros, symbols hand-encoded
    set_info(32'hB000, 16);
    set_syms(64'hD2B0_0000, 16);
    send_frame(0, 1);
    wait_empty("frame_1011_done");
    info.delete();
    syms.delete();
    for (int i = 0; i < 100; i++) begin
      info.push_back(1'b0);
      syms.push_back(2'b00);
    end
    pm_watch = 1'b1;
    send_frame(0, 1);
    wait_empty("frame_zero100_done");
    pm_watch = 1'b0;
    chk("pm0_bounded", int'(pm_max <= 32), 1);
    // same frame, symbol #1 received as 11 instead of 01
    set_info(32'hB000, 16);
    set_syms(64'hF2B0_0000, 16);
    send_frame(0, 1);
    wait_empty("frame_1011_err_done");
    set_info(32'b110, 3);
    set_syms(64'b11_10_10, 3);
    send_frame(0, 1);
    n = 0;
    while (bus.sym_ready !== 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("short_drain_ready_low", n, 3);
    wait_empty("frame_short_done");
    set_info(32'b1, 1);
    set_syms(64'b11, 1);
    send_frame(0, 1);
    wait_empty("frame_single_done");
    info.delete();
    for (int i = 0; i < 1000; i++) info.push_back(1'($urandom_range(0, 1)));
    encode();
    for (int i = 3; i < 1000 - 24; i += 8)
      if ($urandom_range(0, 1) == 1) syms[i] = syms[i] ^ ($urandom_range(0, 1) == 1 ? 2'b10 : 2'b01);
    send_frame(1, 1);
    wait_empty("frame_random_done");
    // reset while draining a short frame: its output is abandoned
    mute = 1'b1;
    set_info(32'b101, 3);
    encode();
    send_frame(0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("drain_rst_bit_valid", int'(bus.bit_valid), 0);
    chk("drain_rst_sym_ready", int'(bus.sym_ready), 1);
    chk("drain_rst_bit_last", int'(bus.bit_last), 0);
    rst = 1'b0;
    mute = 1'b0;
    repeat (2) @(negedge clk);
    set_info(32'hB000, 16);
    set_syms(64'hD2B0_0000, 16);
    send_frame(0, 1);
    wait_empty("frame_after_rst_done");
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end
endmodule
